clk_gate_ctrl: RTL and testbench

Multi-channel clock-gating controller for the MAC array. It turns per-channel activity requests into glitch-free gated clocks. Each channel has a hysteresis state machine: once a channel goes idle, its clock stays running for a programmable drain window before it is gated off. The block sits between the MAC-array control logic and the per-column MAC clocks. It replaces single-enable gating with per-channel, timeout-based gating.

---
 rtl/clk_gate_pkg.sv | 11 +
 rtl/clk_gate_cell.sv | 13 +
 rtl/clk_gate_ctrl.sv | 72 +++++++
 tb/tb_clk_gate_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gate_pkg.sv
// clk_gate_pkg: channel FSM state encoding and default sizing for clk_gate_ctrl
package clk_gate_pkg;
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_DRAIN = 2'd2
  } ch_state_e;
  localparam int DEF_NUM_CH = 8;
  localparam int DEF_CNT_W  = 4;
  localparam int DEF_STAT_W = 16;
endpackage

// File: rtl/clk_gate_cell.sv
// clk_gate_cell: latch-based glitch-free clock gate, stand-in for the library ICG
module clk_gate_cell (
  input  logic clk,
  input  logic en,
  input  logic test_en,
  output logic gated_clk
);
  logic en_l;
  always_latch begin
    if (!clk) en_l = en;
  end
  assign gated_clk = clk & (en_l | test_en);
endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: per-channel hysteresis clock gating with a programmable drain window
// Optional CLK_GATE_STATS_EN adds saturating per-channel gated-cycle counters on gated_cnt.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
`ifdef CLK_GATE_STATS_EN
  , parameter int STAT_W = DEF_STAT_W
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] active,
  input  logic              force_on,
  input  logic              test_en,
  input  logic [CNT_W-1:0]  idle_timeout,
  output logic [NUM_CH-1:0] gated_clk,
  output logic [NUM_CH-1:0] ch_on,
  output logic              all_idle
`ifdef CLK_GATE_STATS_EN
  , output logic [NUM_CH*STAT_W-1:0] gated_cnt
`endif
);
  logic [NUM_CH-1:0] off_d;
  logic              all_idle_q;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req;
    always_comb begin
      req   = active[i] | force_on;
      st_d  = req ? ST_ON
            : st_q == ST_ON ? ST_DRAIN
            : (st_q == ST_DRAIN && cnt_q != '0) ? ST_DRAIN : ST_OFF;
      cnt_d = req ? '0
            : st_q == ST_ON ? idle_timeout
            : (st_q == ST_DRAIN && cnt_q != '0) ? cnt_q - 1'b1 : '0;
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st_q  <= ST_OFF;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end
    assign ch_on[i] = st_q != ST_OFF;
    assign off_d[i] = st_d == ST_OFF;
    clk_gate_cell u_cell (
      .clk       (clk),
      .en        (ch_on[i]),
      .test_en   (test_en),
      .gated_clk (gated_clk[i])
    );
`ifdef CLK_GATE_STATS_EN
    logic [STAT_W-1:0] stat_q;
    always_ff @(posedge clk) begin
      if (!rst_n) stat_q <= '0;
      else if (st_q == ST_OFF && stat_q != '1) stat_q <= stat_q + 1'b1;
    end
    assign gated_cnt[i*STAT_W +: STAT_W] = stat_q;
`endif
  end
  // Look at next state so all_idle flips on the same edge the last channel turns off.
  always_ff @(posedge clk) begin
    if (!rst_n) all_idle_q <= 1'b1;
    else all_idle_q <= &off_d;
  end
  assign all_idle = all_idle_q;
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed tests with a timing-level model of clk_gate_ctrl
module tb_clk_gate_ctrl;
  localparam int N  = 8;
  localparam int CW = 4;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] active;
  logic         force_on, test_en;
  logic [CW-1:0] idle_timeout;
  logic [N-1:0] gated_clk, ch_on;
  logic         all_idle;
`ifdef CLK_GATE_STATS_EN
  localparam int SW = 4;
  logic [N*SW-1:0] gated_cnt;
  int st_exp [N];
`endif
  int checks = 0;
  int failures = 0;

  clk_gate_ctrl #(
    .NUM_CH(N), .CNT_W(CW)
`ifdef CLK_GATE_STATS_EN
    , .STAT_W(SW)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .active       (active),
    .force_on     (force_on),
    .test_en      (test_en),
    .idle_timeout (idle_timeout),
    .gated_clk    (gated_clk),
    .ch_on        (ch_on),
    .all_idle     (all_idle)
`ifdef CLK_GATE_STATS_EN
    , .gated_cnt  (gated_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: a channel runs while a request was seen at edge L and the current edge k <= L+T+1,
  // where T is idle_timeout sampled on the first request-free edge after L.
  int           k = 0;
  int           last [N];
  int           tmo  [N];
  logic [N-1:0] exp_on = '0;
  logic         exp_idle = 1'b1;
  always @(posedge clk) begin
    k++;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        exp_on[i] = 1'b0;
`ifdef CLK_GATE_STATS_EN
        st_exp[i] = 0;
`endif
      end else begin
`ifdef CLK_GATE_STATS_EN
        if (!exp_on[i] && st_exp[i] < (1 << SW) - 1) st_exp[i]++;
`endif
        if (active[i] || force_on) begin
          exp_on[i] = 1'b1;
          last[i] = k;
        end else if (exp_on[i]) begin
          if (k == last[i] + 1) tmo[i] = int'(idle_timeout);
          if (k > last[i] + tmo[i] + 1) exp_on[i] = 1'b0;
        end
      end
    end
    exp_idle = exp_on == '0;
  end

  always @(negedge clk) begin
    if (k >= 1) begin
      chk("ch_on_model", 32'(ch_on), 32'(exp_on));
      chk("all_idle_model", 32'(all_idle), 32'(exp_idle));
`ifdef CLK_GATE_STATS_EN
      for (int i = 0; i < N; i++) chk("gated_cnt_model", 32'(gated_cnt[i*SW +: SW]), 32'(st_exp[i]));
`endif
    end
  end

  int     pc [N];
  time    rise_t [N];
  logic   rise_seen [N];
  for (genvar g = 0; g < N; g++) begin : g_mon
    initial begin
      pc[g] = 0;
      rise_seen[g] = 1'b0;
    end
    always @(posedge gated_clk[g]) begin
      pc[g]++;
      rise_t[g] = $time;
      rise_seen[g] = 1'b1;
    end
    always @(negedge gated_clk[g]) if (rise_seen[g]) chk("pulse_width_ok", 32'($time - rise_t[g] >= 5), 32'd1);
  end

  initial begin
    rst_n = 1'b0;
    active = '1;
    force_on = 1'b0;
    test_en = 1'b0;
    idle_timeout = 4'd3;
    repeat (3) begin
      step(1);
      chk("rst_ch_on", 32'(ch_on), 32'h0);
      chk("rst_all_idle", 32'(all_idle), 32'h1);
      chk("rst_gated_clk", 32'(gated_clk), 32'h0);
    end
    rst_n = 1'b1;
    step(1);
    chk("wake_all", 32'(ch_on), 32'hFF);
    active = '0;
    step(4);
    chk("drain_all_on", 32'(ch_on), 32'hFF);
    step(1);
    chk("drain_all_off", 32'(ch_on), 32'h0);
    chk("drain_all_idle", 32'(all_idle), 32'h1);
    // wake/sleep on channel 0 with T=3
    pc[0] = 0;
    active = 8'h01;
    step(1);
    chk("ws_wake", 32'(ch_on[0]), 32'h1);
    step(4);
    active = '0;
    step(4);
    chk("ws_drain_on", 32'(ch_on[0]), 32'h1);
    step(1);
    chk("ws_off", 32'(ch_on[0]), 32'h0);
    step(2);
    chk("ws_pulses", 32'(pc[0]), 32'd9);
    // drain re-entry on channel 2 with T=5, timeout changed mid-drain
    idle_timeout = 4'd5;
    active = 8'h04;
    step(2);
    active = '0;
    step(2);
    chk("re_mid_drain", 32'(ch_on[2]), 32'h1);
    active = 8'h04;
    step(1);
    chk("re_back_on", 32'(ch_on[2]), 32'h1);
    active = '0;
    step(1);
    idle_timeout = 4'd1;
    step(5);
    chk("re_full_drain", 32'(ch_on[2]), 32'h1);
    step(1);
    chk("re_off", 32'(ch_on[2]), 32'h0);
    // idle_timeout = 0 boundary
    idle_timeout = 4'd0;
    pc[1] = 0;
    active = 8'h02;
    step(1);
    active = '0;
    chk("t0_on", 32'(ch_on), 32'h02);
    chk("t0_busy", 32'(all_idle), 32'h0);
    step(1);
    chk("t0_drain", 32'(ch_on[1]), 32'h1);
    step(1);
    chk("t0_off", 32'(ch_on[1]), 32'h0);
    chk("t0_idle", 32'(all_idle), 32'h1);
    step(2);
    chk("t0_pulses", 32'(pc[1]), 32'd2);
    // force_on override
    force_on = 1'b1;
    step(1);
    chk("force_on", 32'(ch_on), 32'hFF);
    force_on = 1'b0;
    step(1);
    chk("force_drain", 32'(ch_on), 32'hFF);
    step(1);
    chk("force_off", 32'(all_idle), 32'h1);
    // test_en bypass while every channel is off
    test_en = 1'b1;
    #1 chk("test_low", 32'(gated_clk), 32'h0);
    @(posedge clk);
    #1 chk("test_high", 32'(gated_clk), 32'hFF);
    @(negedge clk);
    #1 chk("test_low2", 32'(gated_clk), 32'h0);
    test_en = 1'b0;
    // reset while channels are ON forces OFF immediately
    step(1);
    active = '1;
    step(1);
    chk("mid_on", 32'(ch_on), 32'hFF);
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_off", 32'(ch_on), 32'h0);
    chk("mid_rst_idle", 32'(all_idle), 32'h1);
    active = '0;
    rst_n = 1'b1;
    step(2);
`ifdef CLK_GATE_STATS_EN
    step(20);
    chk("stat_sat", 32'(gated_cnt[7*SW +: SW]), 32'hF);
    rst_n = 1'b0;
    step(1);
    chk("stat_clr", 32'(gated_cnt[7*SW +: SW]), 32'h0);
    rst_n = 1'b1;
    step(1);
    chk("stat_one", 32'(gated_cnt[7*SW +: SW]), 32'h1);
`endif
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
